// File: rtl/tis_exec.sv
// -----------------------------------------------------------------------------
// tis_exec
// Execute/sequencer stage of a TIS-100 node. It accepts one decoded
// instruction at a time and resolves its operand (immediate, ACC, NIL or the
// blocking input port). It then performs saturating arithmetic and drives the
// downstream register file's write/swap/save strobes. MOV to the output port
// blocks on a valid/ready handshake.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   instr_valid/instr_ready       instruction handshake
//   instr_op, instr_src, instr_imm decoded instruction fields
//   acc                           current ACC value from the register file
//   rf_write/rf_swap/rf_save      one-cycle register-file strobes (COMMIT only)
//   rf_write_data                 value written to ACC when rf_write is high
//   in_valid/in_ready/in_data     blocking input port
//   out_valid/out_ready/out_data  blocking output port
// -----------------------------------------------------------------------------
module tis_exec #(
   parameter int WORD_W  = 11,
   parameter int SAT_MAX = 999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [1:0]        instr_src,
   input  logic [WORD_W-1:0] instr_imm,
   input  logic [WORD_W-1:0] acc,
   output logic              rf_write,
   output logic              rf_swap,
   output logic              rf_save,
   output logic [WORD_W-1:0] rf_write_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data
);

   typedef enum logic [1:0] {S_READY, S_RD_WAIT, S_COMMIT, S_WR_WAIT} state_t;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_MOV = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_NEG = 3'd4;
   localparam logic [2:0] OP_SWP = 3'd5;
   localparam logic [2:0] OP_SAV = 3'd6;
   localparam logic [2:0] OP_OUT = 3'd7;

   localparam logic [1:0] SRC_IMM  = 2'd0;
   localparam logic [1:0] SRC_ACC  = 2'd1;
   localparam logic [1:0] SRC_PORT = 2'd3;

   // Arithmetic runs one bit wider than a word so that sums cannot wrap
   // before they are clamped.
   localparam logic signed [WORD_W:0] SAT_HI = (WORD_W+1)'(SAT_MAX);
   localparam logic signed [WORD_W:0] SAT_LO = -SAT_HI;

   function automatic logic signed [WORD_W:0] ext(input logic [WORD_W-1:0] v);
      return {v[WORD_W-1], v};
   endfunction

   function automatic logic [WORD_W-1:0] sat(input logic signed [WORD_W:0] v);
      if (v > SAT_HI) return SAT_HI[WORD_W-1:0];
      if (v < SAT_LO) return SAT_LO[WORD_W-1:0];
      return v[WORD_W-1:0];
   endfunction

   function automatic logic [WORD_W-1:0] execute(input logic [2:0]        op,
                                                 input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] opnd);
      logic [WORD_W-1:0] r;
      r = '0;
      case (op)
         OP_MOV, OP_OUT: r = opnd;
         OP_ADD:         r = sat(ext(a) + ext(opnd));
         OP_SUB:         r = sat(ext(a) - ext(opnd));
         OP_NEG:         r = sat(-ext(a));
         default:        r = '0;
      endcase
      return r;
   endfunction

   function automatic state_t after_exec(input logic [2:0] op);
      if (op == OP_NOP) return S_READY;
      if (op == OP_OUT) return S_WR_WAIT;
      return S_COMMIT;
   endfunction

   state_t            state, next_state;
   logic [2:0]        op_q, next_op;
   logic [WORD_W-1:0] data_q, next_data;
   logic [WORD_W-1:0] operand;

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      next_state = state;
      next_op    = op_q;
      next_data  = data_q;
      operand    = '0;
      case (state)
         S_READY: begin
            if (instr_valid) begin
               next_op = instr_op;
               if (instr_src == SRC_PORT &&
                   instr_op inside {OP_MOV, OP_ADD, OP_SUB, OP_OUT}) begin
                  next_state = S_RD_WAIT;
               end else begin
                  case (instr_src)
                     SRC_IMM: operand = sat(ext(instr_imm));
                     SRC_ACC: operand = acc;
                     default: operand = '0;   // NIL, or PORT on an op that ignores src
                  endcase
                  next_data  = execute(instr_op, acc, operand);
                  next_state = after_exec(instr_op);
               end
            end
         end
         S_RD_WAIT: begin
            if (in_valid) begin
               operand    = sat(ext(in_data));
               next_data  = execute(op_q, acc, operand);
               next_state = after_exec(op_q);
            end
         end
         S_COMMIT:  next_state = S_READY;
         S_WR_WAIT: if (out_ready) next_state = S_READY;
         default:   next_state = S_READY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_READY;
         op_q     <= OP_NOP;
         data_q   <= '0;
         rf_write <= 1'b0;
         rf_swap  <= 1'b0;
         rf_save  <= 1'b0;
      end else begin
         state    <= next_state;
         op_q     <= next_op;
         data_q   <= next_data;
         // Strobes are flops loaded on entry to COMMIT, and COMMIT always
         // lasts one cycle. Each strobe is therefore a clean single pulse.
         rf_write <= (next_state == S_COMMIT) &&
                     (next_op inside {OP_MOV, OP_ADD, OP_SUB, OP_NEG});
         rf_swap  <= (next_state == S_COMMIT) && (next_op == OP_SWP);
         rf_save  <= (next_state == S_COMMIT) && (next_op == OP_SAV);
      end
   end

   assign instr_ready   = (state == S_READY);
   assign in_ready      = (state == S_RD_WAIT);
   assign out_valid     = (state == S_WR_WAIT);
   // data_q only changes when an instruction executes, so the output word
   // stays stable for as long as WR_WAIT waits for out_ready.
   assign out_data      = data_q;
   assign rf_write_data = data_q;

endmodule
